// File: rtl/rc4_key_search_mc.sv
// rc4_key_search_mc: multi-channel RC4 key search controller.
// Channel i walks keys i, i+NUM_CH, i+2*NUM_CH, ... up to KEY_LIMIT, driving
// one decrypt core. The controller reports the first valid key (lowest
// channel index on a tie) or no_sol once every channel has run out of keys.
// Optional build macro: KEY_SEARCH_PROGRESS_EN enables the keys_tested counter
// (otherwise keys_tested is tied to zero).
module rc4_key_search_mc #(
    parameter int               KEY_W     = 24,
    parameter int               NUM_CH    = 4,
    parameter logic [KEY_W-1:0] KEY_LIMIT = 24'h3FFFFF,
    parameter int               CH_W      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       dc_done,
    input  logic [NUM_CH-1:0]       dc_invalid,
    output logic [NUM_CH*KEY_W-1:0] sc_key,
    output logic [NUM_CH-1:0]       reset_decrypt,
    output logic [NUM_CH-1:0]       start_decrypt,
    output logic                    found,
    output logic [KEY_W-1:0]        found_key,
    output logic [CH_W-1:0]         found_ch,
    output logic                    no_sol,
    output logic [KEY_W-1:0]        keys_tested
);

    typedef enum logic [1:0] {
        TOP_IDLE  = 2'd0,
        TOP_RUN   = 2'd1,
        TOP_FOUND = 2'd2,
        TOP_NOSOL = 2'd3
    } top_state_t;

    typedef enum logic [2:0] {
        CH_IDLE     = 3'd0,
        CH_RESET_DC = 3'd1,
        CH_WAIT     = 3'd2,
        CH_KEY_INC  = 3'd3,
        CH_EXH      = 3'd4
    } ch_state_t;

    // Limit and stride widened by one bit so the carry of the increment is visible.
    localparam logic [KEY_W:0] LIMIT_EXT = {1'b0, KEY_LIMIT};
    localparam logic [KEY_W:0] STEP      = (KEY_W+1)'(NUM_CH);

    top_state_t        top_state_r;
    top_state_t        top_next_s;
    ch_state_t         ch_state_r  [NUM_CH];
    ch_state_t         ch_next_s   [NUM_CH];
    logic [KEY_W-1:0]  key_r       [NUM_CH];
    logic [KEY_W-1:0]  key_next_s  [NUM_CH];
    logic [KEY_W:0]    sum_s       [NUM_CH];
    logic [NUM_CH-1:0] succ_s;
    logic [NUM_CH-1:0] exh_s;
    logic [NUM_CH-1:0] rst_pulse_s;
    logic [NUM_CH-1:0] wait_next_s;
    logic              any_succ_s;
    logic              all_exh_s;
    logic              hit_s;
    logic [CH_W-1:0]   win_s;
    logic [KEY_W-1:0]  win_key_s;

    // Per-channel status decode and lowest-index winner selection.
    always_comb begin
        succ_s    = '0;
        exh_s     = '0;
        hit_s     = 1'b0;
        win_s     = '0;
        win_key_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            succ_s[i] = (top_state_r == TOP_RUN) && (ch_state_r[i] == CH_WAIT) &&
                        dc_done[i] && !dc_invalid[i];
            exh_s[i]  = (ch_state_r[i] == CH_EXH);
            sum_s[i]  = {1'b0, key_r[i]} + STEP;
            win_s     = (succ_s[i] && !hit_s) ? CH_W'(i) : win_s;
            win_key_s = (succ_s[i] && !hit_s) ? key_r[i] : win_key_s;
            hit_s     = hit_s | succ_s[i];
        end
        any_succ_s = hit_s;
        all_exh_s  = &exh_s;
    end

    // Top-level next-state logic; a success outranks a simultaneous exhaustion.
    always_comb begin
        top_next_s = top_state_r;
        case (top_state_r)
            TOP_IDLE: begin
                if (start) begin
                    top_next_s = TOP_RUN;
                end else begin
                    top_next_s = TOP_IDLE;
                end
            end
            TOP_RUN: begin
                if (any_succ_s) begin
                    top_next_s = TOP_FOUND;
                end else if (all_exh_s) begin
                    top_next_s = TOP_NOSOL;
                end else begin
                    top_next_s = TOP_RUN;
                end
            end
            TOP_FOUND, TOP_NOSOL: begin
                if (start) begin
                    top_next_s = top_state_r;
                end else begin
                    top_next_s = TOP_IDLE;
                end
            end
            default: top_next_s = TOP_IDLE;
        endcase
    end

    // Channel next-state, next-key and core-reset pulse logic.
    always_comb begin
        rst_pulse_s = '0;
        wait_next_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_next_s[i]  = ch_state_r[i];
            key_next_s[i] = key_r[i];
            case (top_state_r)
                TOP_IDLE: begin
                    if (start) begin
                        key_next_s[i] = KEY_W'(i);
                        if ((KEY_W+1)'(i) > LIMIT_EXT) begin
                            ch_next_s[i] = CH_EXH;
                        end else begin
                            ch_next_s[i]   = CH_RESET_DC;
                            rst_pulse_s[i] = 1'b1;
                        end
                    end else begin
                        key_next_s[i] = '0;
                        ch_next_s[i]  = CH_IDLE;
                    end
                end
                TOP_RUN: begin
                    if (any_succ_s || all_exh_s) begin
                        // Search over: park every channel, abort losers still in WAIT.
                        ch_next_s[i]   = CH_IDLE;
                        rst_pulse_s[i] = (ch_state_r[i] == CH_WAIT) && (win_s != CH_W'(i));
                    end else begin
                        case (ch_state_r[i])
                            CH_RESET_DC: ch_next_s[i] = CH_WAIT;
                            CH_WAIT: begin
                                if (dc_done[i] && dc_invalid[i]) begin
                                    ch_next_s[i] = CH_KEY_INC;
                                end else begin
                                    ch_next_s[i] = CH_WAIT;
                                end
                            end
                            CH_KEY_INC: begin
                                if (sum_s[i] > LIMIT_EXT) begin
                                    ch_next_s[i] = CH_EXH;
                                end else if (enable) begin
                                    key_next_s[i]  = sum_s[i][KEY_W-1:0];
                                    ch_next_s[i]   = CH_RESET_DC;
                                    rst_pulse_s[i] = 1'b1;
                                end else begin
                                    ch_next_s[i] = CH_KEY_INC;
                                end
                            end
                            CH_EXH:  ch_next_s[i] = CH_EXH;
                            CH_IDLE: ch_next_s[i] = CH_IDLE;
                            default: ch_next_s[i] = CH_IDLE;
                        endcase
                    end
                end
                TOP_FOUND, TOP_NOSOL: begin
                    if (start) begin
                        ch_next_s[i] = ch_state_r[i];
                    end else begin
                        key_next_s[i] = '0;
                        ch_next_s[i]  = CH_IDLE;
                    end
                end
                default: begin
                    key_next_s[i] = '0;
                    ch_next_s[i]  = CH_IDLE;
                end
            endcase
            wait_next_s[i] = (ch_next_s[i] == CH_WAIT);
        end
    end

    // State, key and core-handshake registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_state_r   <= TOP_IDLE;
            reset_decrypt <= '0;
            start_decrypt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_state_r[i] <= CH_IDLE;
                key_r[i]      <= '0;
            end
        end else begin
            top_state_r   <= top_next_s;
            reset_decrypt <= rst_pulse_s;
            start_decrypt <= wait_next_s;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_state_r[i] <= ch_next_s[i];
                key_r[i]      <= key_next_s[i];
            end
        end
    end

    // Result registers: latch the winner or exhaustion, clear on return to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            found     <= 1'b0;
            found_key <= '0;
            found_ch  <= '0;
            no_sol    <= 1'b0;
        end else if ((top_state_r == TOP_RUN) && any_succ_s) begin
            found     <= 1'b1;
            found_key <= win_key_s;
            found_ch  <= win_s;
        end else if ((top_state_r == TOP_RUN) && all_exh_s) begin
            no_sol <= 1'b1;
        end else if (top_next_s == TOP_IDLE) begin
            found     <= 1'b0;
            found_key <= '0;
            found_ch  <= '0;
            no_sol    <= 1'b0;
        end
    end

    // Flatten the per-channel key registers onto the sc_key bus.
    always_comb begin
        sc_key = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sc_key[i*KEY_W +: KEY_W] = key_r[i];
        end
    end

`ifdef KEY_SEARCH_PROGRESS_EN
    logic [NUM_CH-1:0] inc_enter_s;
    logic [KEY_W:0]    kt_sum_s;
    logic [KEY_W-1:0]  kt_next_s;

    // Number of set bits in a channel vector (at most NUM_CH, fits CH_W+1 bits).
    function automatic logic [CH_W:0] popcount(input logic [NUM_CH-1:0] v);
        logic [CH_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt = cnt + (CH_W+1)'(v[i]);
        end
        return cnt;
    endfunction

    // Saturating sum of rejected keys: channels entering KEY_INC this cycle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            inc_enter_s[i] = (ch_next_s[i] == CH_KEY_INC) && (ch_state_r[i] != CH_KEY_INC);
        end
        kt_sum_s = {1'b0, keys_tested} + (KEY_W+1)'(popcount(inc_enter_s));
        if (kt_sum_s[KEY_W]) begin
            kt_next_s = '1;
        end else begin
            kt_next_s = kt_sum_s[KEY_W-1:0];
        end
    end

    // Progress counter: cleared on search start, advances only while running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keys_tested <= '0;
        end else if ((top_state_r == TOP_IDLE) && start) begin
            keys_tested <= '0;
        end else if (top_state_r == TOP_RUN) begin
            keys_tested <= kt_next_s;
        end
    end
`else
    assign keys_tested = '0;
`endif

endmodule

// File: tb/tb_rc4_key_search_mc.sv
// Directed self-checking bench for rc4_key_search_mc (NUM_CH=4).
// dut uses KEY_LIMIT=15, dut2 uses KEY_LIMIT=2 for the short-subspace case.
module tb_rc4_key_search_mc;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, start2, enable;
    logic [3:0]   dc_done, dc_invalid, dc_done2, dc_invalid2;
    logic [95:0]  sc_key, sc_key2;
    logic [3:0]   reset_decrypt, start_decrypt, reset_decrypt2, start_decrypt2;
    logic         found, no_sol, found2, no_sol2;
    logic [23:0]  found_key, keys_tested, found_key2, keys_tested2;
    logic [3:0]   found_ch, found_ch2;

    logic [3:0]        cur_en;
    logic [3:0][23:0]  cur_key;

    int           total = 0;
    int           bad   = 0;
    int           lcnt  [4];
    int           lcnt2 [4];
    logic [23:0]  lkey  [4][8];
    logic [23:0]  lkey2 [4][8];
    int           cyc;
    int           exp_kt;

    typedef struct {
        logic [3:0]        tgt_en;
        logic [3:0][23:0]  tgt_key;
        logic              exp_found;
        logic [23:0]       exp_key;
        logic [3:0]        exp_ch;
        logic              exp_nosol;
        int                exp_cyc;
        logic [3:0]        exp_abort;
        int                exp_kt;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    rc4_key_search_mc #(.KEY_W(24), .NUM_CH(4), .KEY_LIMIT(24'd15), .CH_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .enable(enable),
        .dc_done(dc_done), .dc_invalid(dc_invalid),
        .sc_key(sc_key), .reset_decrypt(reset_decrypt), .start_decrypt(start_decrypt),
        .found(found), .found_key(found_key), .found_ch(found_ch),
        .no_sol(no_sol), .keys_tested(keys_tested)
    );

    rc4_key_search_mc #(.KEY_W(24), .NUM_CH(4), .KEY_LIMIT(24'd2), .CH_W(4)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .enable(enable),
        .dc_done(dc_done2), .dc_invalid(dc_invalid2),
        .sc_key(sc_key2), .reset_decrypt(reset_decrypt2), .start_decrypt(start_decrypt2),
        .found(found2), .found_key(found_key2), .found_ch(found_ch2),
        .no_sol(no_sol2), .keys_tested(keys_tested2)
    );

    // Core model: answers in the first WAIT cycle; valid only on the target key.
    always_comb begin
        dc_done     = start_decrypt;
        dc_invalid  = 4'hF;
        dc_done2    = start_decrypt2;
        dc_invalid2 = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (cur_en[c] && (sc_key[c*24 +: 24] == cur_key[c])) begin
                dc_invalid[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock, sample 1ns later, and log the key of every core-reset pulse.
    task automatic step();
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (reset_decrypt[c] && !found && lcnt[c] < 8) begin
                lkey[c][lcnt[c]] = sc_key[c*24 +: 24];
                lcnt[c]++;
            end
            if (reset_decrypt2[c] && !found2 && lcnt2[c] < 8) begin
                lkey2[c][lcnt2[c]] = sc_key2[c*24 +: 24];
                lcnt2[c]++;
            end
        end
    endtask

    task automatic clear_logs();
        for (int c = 0; c < 4; c++) begin
            lcnt[c]  = 0;
            lcnt2[c] = 0;
        end
    endtask

    initial begin
        vecs[0] = '{tgt_en:4'b0000, tgt_key:{24'd0, 24'd0, 24'd0, 24'd0},
                    exp_found:1'b0, exp_key:24'd0, exp_ch:4'd0, exp_nosol:1'b1,
                    exp_cyc:13, exp_abort:4'b0000, exp_kt:16};
        vecs[1] = '{tgt_en:4'b0100, tgt_key:{24'd0, 24'd10, 24'd0, 24'd0},
                    exp_found:1'b1, exp_key:24'd10, exp_ch:4'd2, exp_nosol:1'b0,
                    exp_cyc:8, exp_abort:4'b1011, exp_kt:8};
        vecs[2] = '{tgt_en:4'b1010, tgt_key:{24'd7, 24'd0, 24'd5, 24'd0},
                    exp_found:1'b1, exp_key:24'd5, exp_ch:4'd1, exp_nosol:1'b0,
                    exp_cyc:5, exp_abort:4'b1101, exp_kt:4};
        vecs[3] = '{tgt_en:4'b0001, tgt_key:{24'd0, 24'd0, 24'd0, 24'd0},
                    exp_found:1'b1, exp_key:24'd0, exp_ch:4'd0, exp_nosol:1'b0,
                    exp_cyc:2, exp_abort:4'b1110, exp_kt:0};
        vecs[4] = '{tgt_en:4'b1000, tgt_key:{24'd15, 24'd0, 24'd0, 24'd0},
                    exp_found:1'b1, exp_key:24'd15, exp_ch:4'd3, exp_nosol:1'b0,
                    exp_cyc:11, exp_abort:4'b0111, exp_kt:12};
        vecs[5] = '{tgt_en:4'b1001, tgt_key:{24'd3, 24'd0, 24'd0, 24'd12},
                    exp_found:1'b1, exp_key:24'd3, exp_ch:4'd3, exp_nosol:1'b0,
                    exp_cyc:2, exp_abort:4'b0111, exp_kt:0};

        reset   = 1'b1;
        start   = 1'b0;
        start2  = 1'b0;
        enable  = 1'b1;
        cur_en  = 4'b0000;
        cur_key = '0;
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_sc_key", sc_key, 96'd0);
        check("reset_found", {found, no_sol, found_ch}, 6'd0);
        check("reset_found_key", found_key, 24'd0);
        check("reset_handshake", {reset_decrypt, start_decrypt}, 8'd0);
        check("reset_keys_tested", keys_tested, 24'd0);
        reset = 1'b0;
        step();

        // Table-driven searches on dut.
        for (int r = 0; r < 6; r++) begin
            cur_en  = vecs[r].tgt_en;
            cur_key = vecs[r].tgt_key;
            clear_logs();
`ifdef KEY_SEARCH_PROGRESS_EN
            exp_kt = vecs[r].exp_kt;
`else
            exp_kt = 0;
`endif
            start = 1'b1;
            step();
            check($sformatf("r%0d_load", r), sc_key, {24'd3, 24'd2, 24'd1, 24'd0});
            cyc = 0;
            for (int n = 1; n <= 40 && cyc == 0; n++) begin
                step();
                if (found || no_sol) cyc = n;
            end
            check($sformatf("r%0d_cycles", r), cyc, vecs[r].exp_cyc);
            check($sformatf("r%0d_found", r), found, vecs[r].exp_found);
            check($sformatf("r%0d_no_sol", r), no_sol, vecs[r].exp_nosol);
            check($sformatf("r%0d_found_key", r), found_key, vecs[r].exp_key);
            check($sformatf("r%0d_found_ch", r), found_ch, vecs[r].exp_ch);
            check($sformatf("r%0d_start_dec", r), start_decrypt, 4'b0000);
            check($sformatf("r%0d_abort", r), reset_decrypt, vecs[r].exp_abort);
            check($sformatf("r%0d_keys_tested", r), keys_tested, exp_kt);
            if (vecs[r].exp_nosol) begin
                for (int c = 0; c < 4; c++) begin
                    check($sformatf("r%0d_ch%0d_nkeys", r, c), lcnt[c], 4);
                    for (int k = 0; k < 4; k++) begin
                        check($sformatf("r%0d_ch%0d_key%0d", r, c, k), lkey[c][k], c + 4*k);
                    end
                end
            end
            repeat (3) step();
            check($sformatf("r%0d_hold", r), {found, no_sol, found_ch, reset_decrypt, start_decrypt},
                  {vecs[r].exp_found, vecs[r].exp_nosol, vecs[r].exp_ch, 8'd0});
            check($sformatf("r%0d_hold_key", r), found_key, vecs[r].exp_key);
            start = 1'b0;
            step();
            check($sformatf("r%0d_clear", r), {found, no_sol, found_ch}, 6'd0);
            check($sformatf("r%0d_clear_key", r), found_key, 24'd0);
            check($sformatf("r%0d_clear_sc_key", r), sc_key, 96'd0);
            step();
        end

        // Pause: enable low while ch0 sits in KEY_INC with key 4.
        cur_en = 4'b0000;
        start  = 1'b1;
        step();
        repeat (5) step();
        check("pause_pre_key", sc_key[23:0], 24'd4);
        enable = 1'b0;
        step();
        check("pause_key_a", sc_key[23:0], 24'd4);
        check("pause_rst_a", reset_decrypt[0], 1'b0);
        step();
        check("pause_key_b", sc_key[23:0], 24'd4);
        check("pause_rst_b", reset_decrypt[0], 1'b0);
        enable = 1'b1;
        step();
        check("resume_key", sc_key[23:0], 24'd8);
        check("resume_rst", reset_decrypt[0], 1'b1);
        reset = 1'b1;
        start = 1'b0;
        #3;
        reset = 1'b0;
        step();

        // Asynchronous reset in the middle of WAIT, then restart with start held.
        start = 1'b1;
        step();
        step();
        check("mid_wait_start_dec", start_decrypt, 4'hF);
        #2;
        reset = 1'b1;
        #1;
        check("async_sc_key", sc_key, 96'd0);
        check("async_handshake", {reset_decrypt, start_decrypt}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("restart_sc_key", sc_key, {24'd3, 24'd2, 24'd1, 24'd0});
        check("restart_rst_dec", reset_decrypt, 4'hF);
        reset = 1'b1;
        start = 1'b0;
        #3;
        reset = 1'b0;
        step();

        // KEY_LIMIT=2: ch3 never runs, ch0..2 test one key each.
        clear_logs();
        start2 = 1'b1;
        step();
        check("lim2_load", sc_key2, {24'd3, 24'd2, 24'd1, 24'd0});
        check("lim2_rst_dec", reset_decrypt2, 4'b0111);
        cyc = 0;
        for (int n = 1; n <= 20 && cyc == 0; n++) begin
            step();
            if (found2 || no_sol2) cyc = n;
        end
        check("lim2_cycles", cyc, 4);
        check("lim2_result", {found2, no_sol2}, 2'b01);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("lim2_ch%0d_nkeys", c), lcnt2[c], 1);
            check($sformatf("lim2_ch%0d_key", c), lkey2[c][0], c);
        end
        check("lim2_ch3_nkeys", lcnt2[3], 0);
        start2 = 1'b0;
        step();
        check("lim2_clear", no_sol2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
